compat_integral_trigger: RTL and testbench
==========================================

# compat_integral_trigger

Downstream consumer of the three per-PMT 40 MHz compatibility integrals. It compares each integral against a per-PMT threshold and forms an N-of-3 coincidence. It emits a single-cycle trigger pulse, then enforces a dead time and a re-arm condition so that one long signal produces exactly one trigger. It sits between the integral stages and the trigger OR / trigger-type logic in the SDE trigger block.

## Interface
- INTEGRAL_BITS, default 19: width of each integral and threshold input; matches the integral stage output width.
- DEAD_SAMPLES, default 8: number of 40 MHz sample points ignored after a trigger; legal range 1..255.
- COUNT_BITS, default 16: width of the trigger counter.

- CLK  in  1  120 MHz system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE40  in  2  phase counter, same signal that drives the integral stages (0,1,2 repeating).
- INTEGRAL0/1/2  in  INTEGRAL_BITS  unsigned integrals; registered by the integral stage on phase 0.
- THRES0/1/2  in  INTEGRAL_BITS  unsigned per-PMT thresholds; quasi-static.
- PMT_MASK  in  3  bit i enables PMT i in the coincidence.
- MULTIPLICITY  in  2  required number of PMTs over threshold; 0 disables the trigger.
- TRIG  out  1  one-CLK trigger pulse.
- TRIG_COUNT  out  COUNT_BITS  number of triggers since reset; saturates.
- ARMED  out  1  high when in IDLE (able to trigger).

## Operation
- Sample point: a cycle with ENABLE40==1. Integrals are stable on that cycle, one cycle after the phase-0 update. ENABLE40 values 0, 2 and 3 are non-sample cycles.
- Per-PMT hit: hit_i = PMT_MASK[i] & (INTEGRAL_i > THRES_i), as a strict unsigned compare. Inputs are read live on the sample cycle; nothing is latched.
- Coincidence: n = hit_0+hit_1+hit_2 (2 bits). coinc = (MULTIPLICITY!=0) & (n >= MULTIPLICITY).
- State machine, with transitions evaluated only on sample cycles except FIRE:
  - IDLE: if coinc, go to FIRE.
  - FIRE: lasts exactly one CLK; TRIG=1. Load dead counter with DEAD_SAMPLES, then go to DEAD unconditionally.
  - DEAD: each sample decrements the counter. On the sample where the counter equals 1, go to REARM.
  - REARM: on a sample, if !coinc go to IDLE, else stay. A continuous over-threshold signal never retriggers.
- TRIG_COUNT increments on every FIRE cycle and saturates at all-ones (no wrap).
- ARMED = (state==IDLE).
- Changing MULTIPLICITY to 0 while in DEAD or REARM does not abort the sequence. REARM then exits on the next sample, because coinc=0.

## Timing
- Reset values: TRIG=0, TRIG_COUNT=0, ARMED=1 (state IDLE), dead counter=0.
- RESET asserted in any state returns the block to IDLE on the next edge. Any pending TRIG is suppressed, and RESET has priority over FIRE.
- Latency: a coincidence on the sample cycle c gives TRIG=1 on cycle c+1 (registered), for exactly one cycle. ENABLE40 is 2 during that cycle.
- DEAD consumes the next DEAD_SAMPLES sample points after the triggering sample (k+1..k+DEAD_SAMPLES). REARM is evaluated at sample k+DEAD_SAMPLES+1.
- Minimum spacing for an isolated pulse: next trigger possible at sample k+DEAD_SAMPLES+2. With the default this is 10 samples, i.e. 30 CLK between TRIG pulses.
- The FIRE cycle never coincides with a sample cycle, so the DEAD count is independent of phase alignment.

## Test plan
- Single PMT: MULTIPLICITY=1, PMT_MASK=3'b001, THRES0=100, INTEGRAL0 goes 0→101 for one sample then back to 0. Expect one TRIG, one cycle after that sample, TRIG_COUNT=1; ARMED goes low and returns high 9 samples later.
- Threshold edge: INTEGRAL0=THRES0=100 → no TRIG; INTEGRAL0=101 → TRIG. With PMT_MASK=0, INTEGRAL0=101 → no TRIG.
- Coincidence: MULTIPLICITY=2, INTEGRAL0 and INTEGRAL1 over threshold on different samples → no TRIG; both over on the same sample → TRIG; all three over with MULTIPLICITY=3 → TRIG. MULTIPLICITY=0 with all over → no TRIG.
- Long signal: INTEGRAL0 held over threshold for 50 samples → exactly one TRIG, and the state stays REARM. When it drops, ARMED rises at the first sample below threshold; reapplying it gives a second TRIG.
- Spacing: one-sample pulses every 9 samples with DEAD_SAMPLES=8 → every second pulse triggers; pulses every 10 samples → every pulse triggers, TRIG pulses 30 CLK apart.
- Reset and saturation: RESET during DEAD → ARMED=1 on the next cycle, TRIG_COUNT=0, and a new pulse triggers immediately. With COUNT_BITS=4 and 20 triggers, TRIG_COUNT=15.

Source files
------------

// File: rtl/compat_integral_trigger.sv
// N-of-3 threshold coincidence on the 40 MHz compatibility integrals, producing a
// single-cycle trigger followed by a sample-counted dead time and a re-arm gate.
module compat_integral_trigger #(
    parameter int unsigned INTEGRAL_BITS = 19,
    parameter int unsigned DEAD_SAMPLES  = 8,
    parameter int unsigned COUNT_BITS    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [1:0]               enable40_i,
    input  logic [INTEGRAL_BITS-1:0] integral0_i,
    input  logic [INTEGRAL_BITS-1:0] integral1_i,
    input  logic [INTEGRAL_BITS-1:0] integral2_i,
    input  logic [INTEGRAL_BITS-1:0] thres0_i,
    input  logic [INTEGRAL_BITS-1:0] thres1_i,
    input  logic [INTEGRAL_BITS-1:0] thres2_i,
    input  logic [2:0]               pmt_mask_i,
    input  logic [1:0]               multiplicity_i,
    output logic                     trig_o,
    output logic [COUNT_BITS-1:0]    trig_count_o,
    output logic                     armed_o
);

    localparam int unsigned DEAD_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_DEAD,
        ST_REARM
    } state_t;

    state_t                state_q, state_d;
    logic [DEAD_BITS-1:0]  dead_cnt_q, dead_cnt_d;
    logic [COUNT_BITS-1:0] trig_count_q, trig_count_d;
    logic                  trig_q;
    logic                  armed_q;

    logic                  sample_c;
    logic [2:0]            hit_c;
    logic [1:0]            n_hits_c;
    logic                  coinc_c;

    // Integrals are stable one cycle after the phase-0 update.
    assign sample_c = (enable40_i == 2'd1);

    assign hit_c[0] = pmt_mask_i[0] & (integral0_i > thres0_i);
    assign hit_c[1] = pmt_mask_i[1] & (integral1_i > thres1_i);
    assign hit_c[2] = pmt_mask_i[2] & (integral2_i > thres2_i);

    assign n_hits_c = 2'(hit_c[0]) + 2'(hit_c[1]) + 2'(hit_c[2]);
    assign coinc_c  = (multiplicity_i != 2'd0) && (n_hits_c >= multiplicity_i);

    // Next-state logic; only FIRE advances on a non-sample cycle.
    always_comb begin
        state_d      = state_q;
        dead_cnt_d   = dead_cnt_q;
        trig_count_d = trig_count_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_c && coinc_c) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                dead_cnt_d = DEAD_BITS'(DEAD_SAMPLES);
                state_d    = ST_DEAD;
            end
            ST_DEAD: begin
                if (sample_c) begin
                    dead_cnt_d = dead_cnt_q - DEAD_BITS'(1);
                    if (dead_cnt_q == DEAD_BITS'(1)) begin
                        state_d = ST_REARM;
                    end
                end
            end
            ST_REARM: begin
                if (sample_c && !coinc_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count moves together with the trigger pulse and sticks at all-ones.
        if ((state_d == ST_FIRE) && (trig_count_q != {COUNT_BITS{1'b1}})) begin
            trig_count_d = trig_count_q + COUNT_BITS'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            dead_cnt_q   <= '0;
            trig_count_q <= '0;
            trig_q       <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            dead_cnt_q   <= dead_cnt_d;
            trig_count_q <= trig_count_d;
            trig_q       <= (state_d == ST_FIRE);
            armed_q      <= (state_d == ST_IDLE);
        end
    end

    assign trig_o       = trig_q;
    assign trig_count_o = trig_count_q;
    assign armed_o      = armed_q;

endmodule

// File: tb/tb_compat_integral_trigger.sv
// Bench for compat_integral_trigger: vector table, directed corner sequences and
// randomized traffic, all checked against a sample-indexed reference model.
module tb_compat_integral_trigger;

    localparam int unsigned IB   = 19;
    localparam int          DEAD = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    enable40 = 2'd0;
    logic [IB-1:0] in0 = '0, in1 = '0, in2 = '0;
    logic [IB-1:0] th0 = 19'd100, th1 = 19'd100, th2 = 19'd100;
    logic [2:0]    mask = 3'b000;
    logic [1:0]    mult = 2'd0;

    logic          trig_o, armed_o;
    logic [15:0]   cnt_o;
    logic          trig_s, armed_s;
    logic [3:0]    cnt_s;

    always #5 clk = ~clk;

    compat_integral_trigger #(.INTEGRAL_BITS(IB), .DEAD_SAMPLES(DEAD), .COUNT_BITS(16)) dut (
        .clk_i(clk), .reset_i(reset), .enable40_i(enable40),
        .integral0_i(in0), .integral1_i(in1), .integral2_i(in2),
        .thres0_i(th0), .thres1_i(th1), .thres2_i(th2),
        .pmt_mask_i(mask), .multiplicity_i(mult),
        .trig_o(trig_o), .trig_count_o(cnt_o), .armed_o(armed_o)
    );

    compat_integral_trigger #(.INTEGRAL_BITS(IB), .DEAD_SAMPLES(DEAD), .COUNT_BITS(4)) dut_sat (
        .clk_i(clk), .reset_i(reset), .enable40_i(enable40),
        .integral0_i(in0), .integral1_i(in1), .integral2_i(in2),
        .thres0_i(th0), .thres1_i(th1), .thres2_i(th2),
        .pmt_mask_i(mask), .multiplicity_i(mult),
        .trig_o(trig_s), .trig_count_o(cnt_s), .armed_o(armed_s)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int p     = 0;

    // Reference model: armed flag, index of the triggering sample, trigger tally.
    bit m_armed = 1'b1;
    bit m_trig  = 1'b0;
    int m_cnt   = 0;
    int m_samp  = 0;
    int m_k     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_coinc();
        int n;
        n = 0;
        if (mask[0] && (in0 > th0)) n++;
        if (mask[1] && (in1 > th1)) n++;
        if (mask[2] && (in2 > th2)) n++;
        return (mult != 2'd0) && (n >= int'(mult));
    endfunction

    // One clock: update the model from the inputs in force, clock, compare.
    task automatic cycle();
        enable40 = 2'(p);
        if (reset) begin
            m_armed = 1'b1;
            m_trig  = 1'b0;
            m_cnt   = 0;
        end else begin
            m_trig = 1'b0;
            if (p == 1) begin
                m_samp++;
                if (m_armed) begin
                    if (m_coinc()) begin
                        m_trig  = 1'b1;
                        m_armed = 1'b0;
                        m_k     = m_samp;
                        m_cnt++;
                    end
                end else if ((m_samp > m_k + DEAD) && !m_coinc()) begin
                    m_armed = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("trig",      32'(trig_o),  32'(m_trig));
        check("armed",     32'(armed_o), 32'(m_armed));
        check("count",     32'(cnt_o),   32'((m_cnt > 65535) ? 65535 : m_cnt));
        check("sat_trig",  32'(trig_s),  32'(m_trig));
        check("sat_armed", 32'(armed_s), 32'(m_armed));
        check("sat_count", 32'(cnt_s),   32'((m_cnt > 15) ? 15 : m_cnt));
        p = (p + 1) % 3;
    endtask

    // Advance through the next sample cycle; its result is visible on return.
    task automatic run_sample();
        while (p != 1) cycle();
        cycle();
    endtask

    task automatic idle_samples(input int n);
        in0 = '0; in1 = '0; in2 = '0;
        for (int i = 0; i < n; i++) run_sample();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic pulse_train(input int period, input int n, input bit chk30, output int ntrig);
        int last;
        last  = -1;
        ntrig = 0;
        for (int i = 0; i < period * n; i++) begin
            in0 = (i % period == 0) ? 19'd101 : 19'd0;
            run_sample();
            if (trig_o) begin
                ntrig++;
                if (chk30 && last >= 0) check("spacing", 32'(cyc - last), 32'd30);
                last = cyc;
            end
        end
        idle_samples(12);
    endtask

    typedef struct {
        logic [2:0] mask;
        logic [1:0] mult;
        logic [IB-1:0] i0, i1, i2;
        bit exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nt, rearm_at;

        vecs[0] = '{3'b001, 2'd1, 19'd100, 19'd0,   19'd0,   1'b0};
        vecs[1] = '{3'b001, 2'd1, 19'd101, 19'd0,   19'd0,   1'b1};
        vecs[2] = '{3'b000, 2'd1, 19'd101, 19'd0,   19'd0,   1'b0};
        vecs[3] = '{3'b111, 2'd2, 19'd101, 19'd0,   19'd0,   1'b0};
        vecs[4] = '{3'b111, 2'd2, 19'd101, 19'd101, 19'd0,   1'b1};
        vecs[5] = '{3'b111, 2'd3, 19'd101, 19'd101, 19'd101, 1'b1};
        vecs[6] = '{3'b111, 2'd0, 19'd500, 19'd500, 19'd500, 1'b0};
        vecs[7] = '{3'b111, 2'd3, 19'd101, 19'd101, 19'd100, 1'b0};
        vecs[8] = '{3'b110, 2'd1, 19'd900, 19'd0,   19'd0,   1'b0};
        vecs[9] = '{3'b110, 2'd1, 19'd0,   19'd0,   19'd101, 1'b1};

        do_reset();
        check("reset_trig",  32'(trig_o),  32'd0);
        check("reset_armed", 32'(armed_o), 32'd1);
        check("reset_count", 32'(cnt_o),   32'd0);

        // Vector table: one sample pattern from the armed state each.
        for (int v = 0; v < 10; v++) begin
            idle_samples(12);
            mask = vecs[v].mask;
            mult = vecs[v].mult;
            in0 = vecs[v].i0; in1 = vecs[v].i1; in2 = vecs[v].i2;
            run_sample();
            check($sformatf("vec%0d", v), 32'(trig_o), 32'(vecs[v].exp));
        end
        idle_samples(12);

        // Coincidence split across samples must not fire.
        mask = 3'b111; mult = 2'd2;
        in0 = 19'd101; in1 = 19'd0; run_sample();
        check("split_a", 32'(trig_o), 32'd0);
        in0 = 19'd0; in1 = 19'd101; run_sample();
        check("split_b", 32'(trig_o), 32'd0);
        idle_samples(12);

        // Single PMT pulse: trig one cycle after the sample, re-armed 9 samples later.
        do_reset();
        mask = 3'b001; mult = 2'd1;
        in0 = 19'd101; run_sample();
        check("single_trig", 32'(trig_o), 32'd1);
        check("single_enable40", 32'(enable40), 32'd1);
        cycle();
        check("single_pulse_width", 32'(trig_o), 32'd0);
        check("single_count", 32'(cnt_o), 32'd1);
        in0 = '0;
        rearm_at = 0;
        for (int s = 1; s <= 20; s++) begin
            run_sample();
            if (armed_o && rearm_at == 0) rearm_at = s;
        end
        check("single_rearm_samples", 32'(rearm_at), 32'd9);

        // Long signal: one trigger, held in re-arm until it drops.
        nt = 0;
        in0 = 19'd101;
        for (int s = 0; s < 50; s++) begin
            run_sample();
            if (trig_o) nt++;
        end
        check("long_ntrig", 32'(nt), 32'd1);
        check("long_armed", 32'(armed_o), 32'd0);
        in0 = '0; run_sample();
        check("long_release", 32'(armed_o), 32'd1);
        in0 = 19'd101; run_sample();
        check("long_second", 32'(trig_o), 32'd1);
        idle_samples(12);

        // Pulse spacing against the dead time.
        pulse_train(9, 10, 1'b0, nt);
        check("period9_ntrig", 32'(nt), 32'd5);
        pulse_train(10, 10, 1'b1, nt);
        check("period10_ntrig", 32'(nt), 32'd10);

        // Reset in the middle of the dead time.
        in0 = 19'd101; run_sample();
        check("pre_reset_trig", 32'(trig_o), 32'd1);
        idle_samples(3);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("rst_armed", 32'(armed_o), 32'd1);
        check("rst_count", 32'(cnt_o), 32'd0);
        in0 = 19'd101; run_sample();
        check("rst_retrig", 32'(trig_o), 32'd1);
        idle_samples(12);

        // Saturation of the narrow counter.
        do_reset();
        pulse_train(10, 20, 1'b0, nt);
        check("sat_ntrig", 32'(nt), 32'd20);
        check("sat_wide", 32'(cnt_o), 32'd20);
        check("sat_narrow", 32'(cnt_s), 32'd15);

        // Randomized traffic against the model.
        th0 = 19'($urandom_range(0, 200));
        th1 = 19'($urandom_range(0, 200));
        th2 = 19'($urandom_range(0, 200));
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) mask = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) mult = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) th0 = 19'($urandom_range(0, 200));
            reset = ($urandom_range(0, 299) == 0);
            in0 = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 400)) : 19'($urandom_range(0, 60));
            in1 = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 400)) : 19'($urandom_range(0, 60));
            in2 = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 400)) : 19'($urandom_range(0, 60));
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
